physics_step: RTL and testbench

//  Per-frame car kinematics stage; sits directly upstream of the collision resolver.
//  - On each frame tick: applies gravity and horizontal acceleration to the velocity, derives the motion

---
 rtl/phys_pkg.sv | 26 ++
 rtl/physics_step_vel_sat.sv | 33 +++
 rtl/physics_step.sv | 227 ++++++++++++++++++++++
 tb/tb_physics_step.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_pkg.sv
// Shared types and helpers for the car kinematics stage and the collision resolver.
package phys_pkg;

    // Step sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        ISSUE,
        WAIT,
        COMMIT
    } phys_state_t;

    // Signed add clamped to [-lim, +lim]; operands are sign-extended to int by the caller,
    // so the sum never wraps for any position width below 31 bits.
    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim) begin
            s = lim;
        end else if (s < -lim) begin
            s = -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/physics_step_vel_sat.sv
// Registered signed saturating accumulator; one instance per velocity axis.
module vel_sat
    import phys_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int          LIM = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic signed [W-1:0] inc,
    output logic signed [W-1:0] sum_c,
    output logic signed [W-1:0] value
);

    // Next accumulator value, exposed so the caller can derive the motion vector in the same cycle.
    always_comb begin
        sum_c = W'(sat_add(int'(value), int'(inc), LIM));
    end

    // Clear wins over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= sum_c;
        end
    end

endmodule

// File: rtl/physics_step.sv
// Per-frame car kinematics: accelerate, hand the motion vector to the collision resolver,
// then commit the resolved position and stop motion on any blocked axis.
module physics_step
    import phys_pkg::*;
#(
    parameter int unsigned POSITION_SIZE = 8,
    parameter int          GRAVITY       = 1,
    parameter int unsigned V_MAX         = 16,
    parameter int unsigned DT            = 1,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            load_in,
    input  logic [POSITION_SIZE-1:0]        init_x_in,
    input  logic [POSITION_SIZE-1:0]        init_y_in,
    input  logic                            frame_in,
    input  logic signed [POSITION_SIZE-1:0] accel_x_in,
    output logic                            coll_begin_out,
    output logic [POSITION_SIZE-1:0]        coll_pos_x_out,
    output logic [POSITION_SIZE-1:0]        coll_pos_y_out,
    output logic signed [POSITION_SIZE-1:0] coll_dx_out,
    output logic signed [POSITION_SIZE-1:0] coll_dy_out,
    input  logic                            coll_result_in,
    input  logic [POSITION_SIZE-1:0]        coll_x_new_in,
    input  logic [POSITION_SIZE-1:0]        coll_y_new_in,
    output logic [POSITION_SIZE-1:0]        pos_x_out,
    output logic [POSITION_SIZE-1:0]        pos_y_out,
    output logic signed [POSITION_SIZE-1:0] vel_x_out,
    output logic signed [POSITION_SIZE-1:0] vel_y_out,
    output logic                            busy_out,
    output logic                            step_done_out,
    output logic                            overrun_out,
    output logic                            timeout_out
);

    localparam int unsigned PS    = POSITION_SIZE;
    localparam int          VLIM  = int'(V_MAX);
    localparam int          DTI   = int'(DT);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic signed [PS-1:0] GRAV_INC = PS'(GRAVITY);

    phys_state_t state;
    phys_state_t state_next;

    logic                 do_load;
    logic                 do_start;
    logic                 do_accel;
    logic                 do_hit;
    logic                 do_expire;
    logic                 blk_x;
    logic                 blk_y;
    logic                 clr_x;
    logic                 clr_y;
    logic signed [PS-1:0] accel_q;
    logic signed [PS-1:0] x_sum;
    logic signed [PS-1:0] y_sum;
    logic [CNT_W-1:0]     wait_cnt;

    // A returned coordinate is blocked when it is not the unwrapped pos+delta.
    always_comb begin
        blk_x = (int'(coll_pos_x_out) + int'(coll_dx_out)) != int'(coll_x_new_in);
        blk_y = (int'(coll_pos_y_out) + int'(coll_dy_out)) != int'(coll_y_new_in);
    end

    // Step sequencer state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes; load beats frame in IDLE, result beats timeout in WAIT.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_start   = 1'b0;
        do_accel   = 1'b0;
        do_hit     = 1'b0;
        do_expire  = 1'b0;
        case (state)
            IDLE: begin
                if (load_in) begin
                    do_load = 1'b1;
                end else if (frame_in) begin
                    do_start   = 1'b1;
                    state_next = ACCEL;
                end
            end
            ACCEL: begin
                do_accel   = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (coll_result_in) begin
                    do_hit     = 1'b1;
                    state_next = COMMIT;
                end else if (wait_cnt == CNT_LAST) begin
                    do_expire  = 1'b1;
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        clr_x = do_load | (do_hit & blk_x);
        clr_y = do_load | (do_hit & blk_y);
    end

    vel_sat #(
        .W   (PS),
        .LIM (VLIM)
    ) u_vel_x (
        .clk   (clk_in),
        .rst   (rst_in),
        .clr   (clr_x),
        .en    (do_accel),
        .inc   (accel_q),
        .sum_c (x_sum),
        .value (vel_x_out)
    );

    vel_sat #(
        .W   (PS),
        .LIM (VLIM)
    ) u_vel_y (
        .clk   (clk_in),
        .rst   (rst_in),
        .clr   (clr_y),
        .en    (do_accel),
        .inc   (GRAV_INC),
        .sum_c (y_sum),
        .value (vel_y_out)
    );

    // Handshake and status pulses, registered so they line up with the state they describe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            coll_begin_out <= 1'b0;
            step_done_out  <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            coll_begin_out <= do_accel;
            step_done_out  <= do_hit;
            busy_out       <= (state_next != IDLE);
        end
    end

    // Acceleration is sampled only when a frame is accepted.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            accel_q <= '0;
        end else if (do_start) begin
            accel_q <= accel_x_in;
        end
    end

    // Resolver payload uses the freshly accelerated velocity and is held until the next step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            coll_pos_x_out <= '0;
            coll_pos_y_out <= '0;
            coll_dx_out    <= '0;
            coll_dy_out    <= '0;
        end else if (do_accel) begin
            coll_pos_x_out <= pos_x_out;
            coll_pos_y_out <= pos_y_out;
            coll_dx_out    <= PS'(sat_add(int'(x_sum) * DTI, 0, VLIM));
            coll_dy_out    <= PS'(sat_add(int'(y_sum) * DTI, 0, VLIM));
        end
    end

    // Resolver wait counter, restarted on the way into WAIT.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Committed position: loaded in IDLE or taken from the resolver result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pos_x_out <= '0;
            pos_y_out <= '0;
        end else if (do_load) begin
            pos_x_out <= init_x_in;
            pos_y_out <= init_y_in;
        end else if (do_hit) begin
            pos_x_out <= coll_x_new_in;
            pos_y_out <= coll_y_new_in;
        end
    end

    // Sticky error flags, cleared only by a load.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overrun_out <= 1'b0;
            timeout_out <= 1'b0;
        end else if (do_load) begin
            overrun_out <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            if (frame_in && (state != IDLE)) begin
                overrun_out <= 1'b1;
            end
            if (do_expire) begin
                timeout_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_physics_step.sv
// Directed bench for physics_step with a scripted resolver and a small kinematics model.
module tb_physics_step;

    localparam int VM = 16;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              load_in;
    logic [7:0]        init_x_in;
    logic [7:0]        init_y_in;
    logic              frame_in;
    logic signed [7:0] accel_x_in;
    logic              coll_begin_out;
    logic [7:0]        coll_pos_x_out;
    logic [7:0]        coll_pos_y_out;
    logic signed [7:0] coll_dx_out;
    logic signed [7:0] coll_dy_out;
    logic              coll_result_in;
    logic [7:0]        coll_x_new_in;
    logic [7:0]        coll_y_new_in;
    logic [7:0]        pos_x_out;
    logic [7:0]        pos_y_out;
    logic signed [7:0] vel_x_out;
    logic signed [7:0] vel_y_out;
    logic              busy_out;
    logic              step_done_out;
    logic              overrun_out;
    logic              timeout_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_begin = 0;
    int n_done  = 0;
    int mpx, mpy, mvx, mvy;

    physics_step #(
        .POSITION_SIZE (8),
        .GRAVITY       (1),
        .V_MAX         (16),
        .DT            (1),
        .TIMEOUT       (8)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .load_in        (load_in),
        .init_x_in      (init_x_in),
        .init_y_in      (init_y_in),
        .frame_in       (frame_in),
        .accel_x_in     (accel_x_in),
        .coll_begin_out (coll_begin_out),
        .coll_pos_x_out (coll_pos_x_out),
        .coll_pos_y_out (coll_pos_y_out),
        .coll_dx_out    (coll_dx_out),
        .coll_dy_out    (coll_dy_out),
        .coll_result_in (coll_result_in),
        .coll_x_new_in  (coll_x_new_in),
        .coll_y_new_in  (coll_y_new_in),
        .pos_x_out      (pos_x_out),
        .pos_y_out      (pos_y_out),
        .vel_x_out      (vel_x_out),
        .vel_y_out      (vel_y_out),
        .busy_out       (busy_out),
        .step_done_out  (step_done_out),
        .overrun_out    (overrun_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk_in) begin
        if (coll_begin_out) n_begin = n_begin + 1;
        if (step_done_out)  n_done  = n_done + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int sat_v(input int v);
        if (v > VM) return VM;
        if (v < -VM) return -VM;
        return v;
    endfunction

    task automatic load_pos(input int x, input int y);
        load_in   = 1'b1;
        init_x_in = 8'(x);
        init_y_in = 8'(y);
        tick();
        load_in = 1'b0;
        mpx = x; mpy = y; mvx = 0; mvy = 0;
    endtask

    // One full frame with a resolver that echoes pos+d, optionally blocking y and poking a frame in WAIT.
    task automatic run_step(input int acc, input bit block_y, input bit poke);
        int b0, d0, ex_dx, ex_dy, nx, ny;
        mvx   = sat_v(mvx + acc);
        mvy   = sat_v(mvy + 1);
        ex_dx = mvx;
        ex_dy = mvy;
        nx    = (mpx + ex_dx) & 255;
        ny    = block_y ? mpy : ((mpy + ex_dy) & 255);
        b0    = n_begin;
        d0    = n_done;
        frame_in   = 1'b1;
        accel_x_in = 8'(acc);
        tick();
        frame_in   = 1'b0;
        accel_x_in = '0;
        check_eq("accel_begin", coll_begin_out, 0);
        check_eq("accel_busy", busy_out, 1);
        tick();
        check_eq("issue_begin", coll_begin_out, 1);
        check_eq("issue_dx", coll_dx_out, ex_dx);
        check_eq("issue_dy", coll_dy_out, ex_dy);
        check_eq("issue_px", coll_pos_x_out, mpx);
        check_eq("issue_py", coll_pos_y_out, mpy);
        tick();
        check_eq("wait_begin", coll_begin_out, 0);
        if (poke) frame_in = 1'b1;
        tick();
        frame_in = 1'b0;
        if (poke) check_eq("overrun_set", overrun_out, 1);
        check_eq("wait_done", step_done_out, 0);
        coll_result_in = 1'b1;
        coll_x_new_in  = 8'(nx);
        coll_y_new_in  = 8'(ny);
        tick();
        coll_result_in = 1'b0;
        if (nx != mpx + ex_dx) mvx = 0;
        if (ny != mpy + ex_dy) mvy = 0;
        mpx = nx;
        mpy = ny;
        check_eq("commit_done", step_done_out, 1);
        check_eq("commit_px", pos_x_out, mpx);
        check_eq("commit_py", pos_y_out, mpy);
        check_eq("commit_vx", vel_x_out, mvx);
        check_eq("commit_vy", vel_y_out, mvy);
        tick();
        check_eq("after_done", step_done_out, 0);
        check_eq("after_busy", busy_out, 0);
        check_eq("begin_count", n_begin - b0, 1);
        check_eq("done_count", n_done - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, d0;
        rst_in = 1'b1; load_in = 1'b0; frame_in = 1'b0; coll_result_in = 1'b0;
        init_x_in = '0; init_y_in = '0; accel_x_in = '0;
        coll_x_new_in = '0; coll_y_new_in = '0;
        tick(); tick();
        check_eq("rst_pos_x", pos_x_out, 0);
        check_eq("rst_vel_y", vel_y_out, 0);
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_begin", coll_begin_out, 0);
        rst_in = 1'b0;
        tick();

        // 1: basic step from (10,20)
        load_pos(10, 20);
        check_eq("load_px", pos_x_out, 10);
        check_eq("load_py", pos_y_out, 20);
        run_step(0, 1'b0, 1'b0);
        check_eq("t1_py", pos_y_out, 21);
        check_eq("t1_vy", vel_y_out, 1);

        // 2: saturation under repeated acceleration
        load_pos(0, 0);
        for (int i = 0; i < 16; i++) run_step(3, 1'b0, 1'b0);
        check_eq("t2_vx", vel_x_out, 16);
        check_eq("t2_vy", vel_y_out, 16);

        // 3: y blocked by the resolver while dy=5
        load_pos(50, 50);
        for (int i = 0; i < 4; i++) run_step(1, 1'b0, 1'b0);
        run_step(0, 1'b1, 1'b0);
        check_eq("t3_vy", vel_y_out, 0);
        check_eq("t3_vx", vel_x_out, 4);
        check_eq("t3_px", pos_x_out, 64);
        check_eq("t3_py", pos_y_out, 60);

        // 4: frame during WAIT is dropped and flagged; load+frame together loads only
        run_step(0, 1'b0, 1'b1);
        b0 = n_begin;
        repeat (4) tick();
        check_eq("t4_no_queue", n_begin - b0, 0);
        check_eq("t4_sticky", overrun_out, 1);
        load_in = 1'b1; frame_in = 1'b1; init_x_in = 8'd70; init_y_in = 8'd80;
        tick();
        load_in = 1'b0; frame_in = 1'b0;
        mpx = 70; mpy = 80; mvx = 0; mvy = 0;
        check_eq("t4_clear", overrun_out, 0);
        check_eq("t4_load_px", pos_x_out, 70);
        check_eq("t4_load_busy", busy_out, 0);
        repeat (3) tick();
        check_eq("t4_load_nobegin", n_begin - b0, 0);

        // 5: resolver never answers
        load_pos(30, 40);
        d0 = n_done;
        frame_in = 1'b1; accel_x_in = 8'sd2;
        tick();
        frame_in = 1'b0; accel_x_in = '0;
        tick(); tick();
        repeat (7) tick();
        check_eq("t5_pre_to", timeout_out, 0);
        check_eq("t5_pre_busy", busy_out, 1);
        tick();
        check_eq("t5_to", timeout_out, 1);
        check_eq("t5_busy", busy_out, 0);
        check_eq("t5_px", pos_x_out, 30);
        check_eq("t5_py", pos_y_out, 40);
        check_eq("t5_nodone", n_done - d0, 0);

        // 6: reset mid-WAIT, then a late result
        load_pos(5, 6);
        frame_in = 1'b1;
        tick();
        frame_in = 1'b0;
        tick(); tick();
        check_eq("t6_busy_pre", busy_out, 1);
        rst_in = 1'b1;
        #1;
        check_eq("t6_rst_px", pos_x_out, 0);
        check_eq("t6_rst_vy", vel_y_out, 0);
        check_eq("t6_rst_dy", coll_dy_out, 0);
        check_eq("t6_rst_busy", busy_out, 0);
        check_eq("t6_rst_to", timeout_out, 0);
        tick();
        rst_in = 1'b0;
        b0 = n_begin; d0 = n_done;
        coll_result_in = 1'b1; coll_x_new_in = 8'd99; coll_y_new_in = 8'd77;
        repeat (3) tick();
        coll_result_in = 1'b0;
        check_eq("t6_late_px", pos_x_out, 0);
        check_eq("t6_late_busy", busy_out, 0);
        check_eq("t6_late_done", n_done - d0, 0);
        check_eq("t6_late_begin", n_begin - b0, 0);
        mpx = 0; mpy = 0; mvx = 0; mvy = 0;
        run_step(0, 1'b0, 1'b0);
        check_eq("t6_next_py", pos_y_out, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
